// File: rtl/rs_decode_scheduler_pkg.sv
// rs_decode_scheduler_pkg: shared constants, FSM state type and ID-width helper
package rs_decode_scheduler_pkg;
   localparam int SYM_N = 7;
   localparam int SYM_W = 3;
   localparam int CW = SYM_N * SYM_W;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
   function automatic int id_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rs_decode_scheduler_if.sv
// rs_decode_scheduler_if: requester and response handshake bundle
interface rs_decode_scheduler_if
   import rs_decode_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int W = CW,
   parameter int IW = id_w(NUM_REQ)
);
   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ*W-1:0] req_codeword;
   logic [NUM_REQ-1:0] req_ready;
   logic resp_valid;
   logic resp_ready;
   logic [W-1:0] resp_codeword;
   logic [IW-1:0] resp_id;
   logic resp_timeout;
   modport master (
      output req_valid, req_codeword, resp_ready,
      input req_ready, resp_valid, resp_codeword, resp_id, resp_timeout
   );
   modport slave (
      input req_valid, req_codeword, resp_ready,
      output req_ready, resp_valid, resp_codeword, resp_id, resp_timeout
   );
endinterface

// File: rtl/rs_decode_scheduler_rr_arbiter.sv
// rs_decode_scheduler_rr_arbiter: combinational round-robin grant starting after ptr
module rs_decode_scheduler_rr_arbiter
   import rs_decode_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 2,
   localparam int IW = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0] ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0] id,
   output logic any
);
   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0] rot;
   assign dbl = {req, req} >> (int'(ptr) + 1);
   assign rot = dbl[NUM_REQ-1:0];
   // bit j of rot is requester ptr+1+j; scanning downward leaves the nearest one
   always_comb begin
      id = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--)
         if (rot[j]) id = IW'((int'(ptr) + 1 + j) % NUM_REQ);
      any = |req;
      grant = any ? NUM_REQ'(1) << id : '0;
   end
endmodule

// File: rtl/rs_decode_scheduler.sv
// rs_decode_scheduler: shares one RS decoder between requesters with round-robin, restart and watchdog
module rs_decode_scheduler
   import rs_decode_scheduler_pkg::*;
#(
   parameter int N = SYM_N,
   parameter int SYMBOL_WIDTH = SYM_W,
   parameter int NUM_REQ = 2,
   parameter int BLANK = 3,
   parameter int TIMEOUT = 31
) (
   input  logic clk,
   input  logic reset,
   rs_decode_scheduler_if.slave bus,
   output logic dec_reset,
   output logic dec_enable,
   output logic [N*SYMBOL_WIDTH-1:0] dec_codeword,
   input  logic [N*SYMBOL_WIDTH-1:0] dec_corrected,
   input  logic dec_rdy,
   output logic busy
);
   localparam int W = N * SYMBOL_WIDTH;
   localparam int IW = id_w(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   state_t state, state_n;
   logic [IW-1:0] rr_ptr, gid;
   logic [NUM_REQ-1:0] grant;
   logic [CNT_W-1:0] cnt;
   logic any, grab, rdy_hit, to_hit;
   rs_decode_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ)) arb (
      .req(bus.req_valid),
      .ptr(rr_ptr),
      .grant(grant),
      .id(gid),
      .any(any)
   );
   assign grab = state == IDLE && any;
   // the decoder's ready is stale from the previous job until its pipeline has drained
   assign rdy_hit = cnt >= CNT_W'(BLANK) && dec_rdy;
   assign to_hit = cnt == CNT_W'(TIMEOUT);
   // state register
   always_ff @(posedge clk) state <= reset ? IDLE : state_n;
   // next-state: one job at a time, a fresh grant only once back in IDLE
   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = any ? LOAD : IDLE;
         LOAD: state_n = RUN;
         RUN:  state_n = (rdy_hit || to_hit) ? RESP : RUN;
         RESP: state_n = bus.resp_ready ? IDLE : RESP;
         default: state_n = IDLE;
      endcase
   end
   // decoder control and status decoded straight from the state register
   always_comb begin
      dec_reset = reset || state == LOAD;
      dec_enable = state == LOAD || state == RUN;
      bus.resp_valid = state == RESP;
      busy = state != IDLE;
   end
   // grant capture, RUN cycle counter and response capture
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= IW'(NUM_REQ - 1);
         bus.req_ready <= '0;
         dec_codeword <= '0;
         bus.resp_id <= '0;
         bus.resp_codeword <= '0;
         bus.resp_timeout <= 1'b0;
         cnt <= '0;
      end else begin
         bus.req_ready <= grab ? grant : '0;
         if (grab) begin
            dec_codeword <= bus.req_codeword[gid*W +: W];
            bus.resp_id <= gid;
            rr_ptr <= gid;
         end
         cnt <= state == LOAD ? '0 : (state == RUN && cnt != '1) ? cnt + 1'b1 : cnt;
         if (state == RUN && (rdy_hit || to_hit)) begin
            bus.resp_codeword <= rdy_hit ? dec_corrected : dec_codeword;
            bus.resp_timeout <= !rdy_hit;
         end
      end
   end
endmodule

// File: tb/tb_rs_decode_scheduler.sv
// tb_rs_decode_scheduler: directed checks of arbitration, latency, stale ready, timeout and reset
module tb_rs_decode_scheduler;
  localparam int N = 7;
  localparam int W = 21;
  localparam int NR = 2;
  logic clk, reset;
  logic dec_reset, dec_enable, dec_rdy, busy;
  logic [W-1:0] dec_codeword, dec_corrected, err_mask;
  int rdy_at;
  int mcnt = 0;
  int tests = 0;
  int fails = 0;
  rs_decode_scheduler_if #(.NUM_REQ(NR), .W(W)) bus ();
  rs_decode_scheduler dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dec_reset(dec_reset),
    .dec_enable(dec_enable),
    .dec_codeword(dec_codeword),
    .dec_corrected(dec_corrected),
    .dec_rdy(dec_rdy),
    .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) mcnt <= dec_reset ? 0 : (dec_enable ? mcnt + 1 : mcnt);
  assign dec_rdy = mcnt >= rdy_at;
  assign dec_corrected = dec_codeword ^ err_mask;

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_codeword = '0;
    bus.resp_ready = 1'b0;
    rdy_at = N + 2;
    err_mask = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (bus.req_ready == '0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.resp_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_codeword = '0;
    bus.resp_ready = 1'b0;
    rdy_at = N + 2;
    err_mask = '0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 2'b00) begin
      fails++;
      $display("FAIL reset_status: busy=%b resp_valid=%b req_ready=%b, want 0 0 00", busy, bus.resp_valid, bus.req_ready);
    end
    tests++;
    if (dec_reset !== 1'b1 || dec_enable !== 1'b0) begin
      fails++;
      $display("FAIL reset_dec_ctrl: dec_reset=%b dec_enable=%b, want 1 0", dec_reset, dec_enable);
    end
    tests++;
    if (bus.resp_codeword !== '0 || bus.resp_id !== 1'b0 || bus.resp_timeout !== 1'b0 || dec_codeword !== '0) begin
      fails++;
      $display("FAIL reset_data: resp_cw=%h id=%h to=%b dec_cw=%h, want all zero", bus.resp_codeword, bus.resp_id, bus.resp_timeout, dec_codeword);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (dec_reset !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: dec_reset=%b, want 0", dec_reset);
    end
  endtask

  task automatic test_single();
    int cyc;
    do_reset();
    bus.req_codeword = {21'o1234567, 21'o0000000};
    bus.resp_ready = 1'b1;
    bus.req_valid = 2'b01;
    wait_ready(cyc);
    tests++;
    if (cyc != 1 || bus.req_ready !== 2'b01) begin
      fails++;
      $display("FAIL single_grant: req_ready=%b after %0d cycles, want 01 after 1", bus.req_ready, cyc);
    end
    bus.req_valid = 2'b00;
    wait_valid(cyc);
    tests++;
    if (cyc != 11) begin
      fails++;
      $display("FAIL single_latency: %0d cycles, want 11", cyc);
    end
    tests++;
    if (bus.resp_codeword !== 21'o0 || bus.resp_id !== 1'b0 || bus.resp_timeout !== 1'b0) begin
      fails++;
      $display("FAIL single_resp: cw=%h id=%h to=%b, want 0 0 0", bus.resp_codeword, bus.resp_id, bus.resp_timeout);
    end
    @(negedge clk);
    tests++;
    if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_release: resp_valid=%b busy=%b, want 0 0", bus.resp_valid, busy);
    end
  endtask

  task automatic test_correct();
    int cyc;
    do_reset();
    err_mask = 21'o0003000;
    bus.req_codeword = {21'o5556555, 21'o7777777};
    bus.resp_ready = 1'b1;
    bus.req_valid = 2'b10;
    wait_ready(cyc);
    tests++;
    if (bus.req_ready !== 2'b10) begin
      fails++;
      $display("FAIL correct_grant: req_ready=%b, want 10", bus.req_ready);
    end
    bus.req_valid = 2'b00;
    wait_valid(cyc);
    tests++;
    if (cyc != 11 || bus.resp_codeword !== 21'o5555555 || bus.resp_id !== 1'b1 || bus.resp_timeout !== 1'b0) begin
      fails++;
      $display("FAIL correct_resp: cyc=%0d cw=%o id=%h to=%b, want 11 5555555 1 0", cyc, bus.resp_codeword, bus.resp_id, bus.resp_timeout);
    end
    tests++;
    if (dec_codeword !== 21'o5556555) begin
      fails++;
      $display("FAIL correct_hold: dec_codeword=%o, want 5556555", dec_codeword);
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int cyc;
    do_reset();
    bus.req_codeword = {21'o2222222, 21'o1111111};
    bus.resp_ready = 1'b1;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ready(cyc);
      tests++;
      if (bus.req_ready !== (i % 2 ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL fair_grant%0d: req_ready=%b, want %b", i, bus.req_ready, i % 2 ? 2'b10 : 2'b01);
      end
      wait_valid(cyc);
      if (i == 3) bus.req_valid = 2'b00;
      tests++;
      if (bus.resp_id !== 1'(i % 2) || bus.resp_codeword !== (i % 2 ? 21'o2222222 : 21'o1111111)) begin
        fails++;
        $display("FAIL fair_resp%0d: id=%h cw=%o, want %0d %o", i, bus.resp_id, bus.resp_codeword, i % 2, i % 2 ? 21'o2222222 : 21'o1111111);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stale_ready();
    int cyc;
    do_reset();
    rdy_at = 0;
    err_mask = 21'o0000007;
    bus.req_codeword = {21'o0000000, 21'o7654321};
    bus.resp_ready = 1'b1;
    bus.req_valid = 2'b01;
    wait_ready(cyc);
    bus.req_valid = 2'b00;
    wait_valid(cyc);
    tests++;
    if (cyc != 5) begin
      fails++;
      $display("FAIL stale_latency: %0d cycles, want 5", cyc);
    end
    tests++;
    if (bus.resp_codeword !== 21'o7654326 || bus.resp_timeout !== 1'b0) begin
      fails++;
      $display("FAIL stale_resp: cw=%o to=%b, want 7654326 0", bus.resp_codeword, bus.resp_timeout);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int cyc;
    do_reset();
    rdy_at = 1000;
    err_mask = 21'o0000001;
    bus.req_codeword = {21'o3333333, 21'o0000000};
    bus.resp_ready = 1'b1;
    bus.req_valid = 2'b10;
    wait_ready(cyc);
    bus.req_valid = 2'b00;
    wait_valid(cyc);
    tests++;
    if (cyc != 33) begin
      fails++;
      $display("FAIL timeout_latency: %0d cycles, want 33", cyc);
    end
    tests++;
    if (bus.resp_timeout !== 1'b1 || bus.resp_codeword !== 21'o3333333 || bus.resp_id !== 1'b1) begin
      fails++;
      $display("FAIL timeout_resp: to=%b cw=%o id=%h, want 1 3333333 1", bus.resp_timeout, bus.resp_codeword, bus.resp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_tie();
    int cyc;
    do_reset();
    rdy_at = 31;
    err_mask = 21'o0000070;
    bus.req_codeword = {21'o0000000, 21'o1234567};
    bus.resp_ready = 1'b1;
    bus.req_valid = 2'b01;
    wait_ready(cyc);
    bus.req_valid = 2'b00;
    wait_valid(cyc);
    tests++;
    if (cyc != 33 || bus.resp_timeout !== 1'b0 || bus.resp_codeword !== 21'o1234517) begin
      fails++;
      $display("FAIL tie_resp: cyc=%0d to=%b cw=%o, want 33 0 1234517", cyc, bus.resp_timeout, bus.resp_codeword);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure_reset();
    int cyc;
    logic seen;
    do_reset();
    bus.req_codeword = {21'o5050505, 21'o4444444};
    bus.resp_ready = 1'b0;
    bus.req_valid = 2'b11;
    wait_ready(cyc);
    wait_valid(cyc);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (bus.resp_valid !== 1'b1 || bus.resp_codeword !== 21'o4444444 || bus.resp_id !== 1'b0 || bus.req_ready !== 2'b00) begin
        fails++;
        $display("FAIL hold%0d: valid=%b cw=%o id=%h req_ready=%b, want 1 4444444 0 00", i, bus.resp_valid, bus.resp_codeword, bus.resp_id, bus.req_ready);
      end
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    wait_ready(cyc);
    tests++;
    if (bus.req_ready !== 2'b10) begin
      fails++;
      $display("FAIL bp_next_grant: req_ready=%b, want 10", bus.req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || dec_enable !== 1'b1 || dec_reset !== 1'b0) begin
      fails++;
      $display("FAIL bp_run: busy=%b en=%b dec_reset=%b, want 1 1 0", busy, dec_enable, dec_reset);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || bus.resp_valid !== 1'b0 || dec_reset !== 1'b1 || bus.req_ready !== 2'b00) begin
      fails++;
      $display("FAIL mid_reset: busy=%b valid=%b dec_reset=%b req_ready=%b, want 0 0 1 00", busy, bus.resp_valid, dec_reset, bus.req_ready);
    end
    reset = 1'b0;
    bus.req_valid = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL dropped_job: resp_valid seen=%b after reset, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_correct();
    test_fairness();
    test_stale_ready();
    test_timeout();
    test_tie();
    test_backpressure_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
